food_placer: RTL and testbench
==============================

# food_placer

Consumer side of the food-position stream: takes the free-running random candidate coordinates produced each cycle, validates them against the playfield (bounds and cell occupancy via the grid memory read port), and commits the accepted position by writing a food block into the grid. After a bounded number of rejected random candidates it falls back to a deterministic raster scan of the interior, so placement always completes. It sits between the game-control FSM, the food randomizer and the grid block memory.

## Interface

- GRID_WIDTH, 32, playfield columns including the wall border.
- GRID_HEIGHT, 24, playfield rows including the wall border.
- BITS_PER_BLOCK, 2, width of one grid cell code.
- BLOCK_EMPTY, 0, code of a free cell.
- BLOCK_FOOD, 3, code written for food.
- MAX_TRIES, 8, random candidates tried (1..255) before the raster scan starts.

- MasterClock  in  1  sole clock, rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- PlaceReq  in  1  level; request placement of one food item. Sampled only in IDLE.
- CandV  in  clog2(GRID_HEIGHT)  candidate row from the randomizer, arbitrary value every cycle.
- CandH  in  clog2(GRID_WIDTH)  candidate column from the randomizer.
- RdV / RdH  out  clog2(H) / clog2(W)  grid read address.
- RdData  in  BITS_PER_BLOCK  cell at the address presented in the previous cycle.
- WrEn  out  1  one-cycle grid write strobe.
- WrV / WrH  out  clog2(H) / clog2(W)  grid write address.
- WrData  out  BITS_PER_BLOCK  equals BLOCK_FOOD whenever WrEn is high.
- PlaceBusy  out  1  high in every state except IDLE.
- PlaceDone  out  1  one-cycle pulse, coincident with WrEn.
- PlaceFail  out  1  one-cycle pulse when no empty interior cell exists.
- FoodV / FoodH  out  widths as above  registered position of the last committed food.
- FoodValid  out  1  FoodV/FoodH hold a committed position.

## Operation

- Interior cell: 1 <= V <= GRID_HEIGHT-2 and 1 <= H <= GRID_WIDTH-2. Cells outside the interior are never read or written.
- States: IDLE, SAMPLE, READ, CHECK, WRITE, FAIL. A Mode flag selects RANDOM or SCAN. An 8-bit Tries counter and TryV/TryH registers complete the datapath.
- IDLE: if PlaceReq is high, clear Tries, set Mode to RANDOM and go to SAMPLE.
- SAMPLE (RANDOM only): latch CandV/CandH into TryV/TryH.
  - If the candidate is interior, go to READ.
  - Otherwise increment Tries and perform no read. If Tries reaches MAX_TRIES, enter SCAN at (1,1) and go to READ. Otherwise stay in SAMPLE.
- READ: RdV/RdH = TryV/TryH. Go to CHECK.
- CHECK: compare RdData with BLOCK_EMPTY.
  - Equal: go to WRITE.
  - RANDOM and not equal: increment Tries. If Tries reaches MAX_TRIES, enter SCAN at (1,1) and go to READ. Otherwise go to SAMPLE.
  - SCAN and not equal: advance TryH. If TryH was GRID_WIDTH-2, set TryH to 1 and increment TryV. If TryV was already GRID_HEIGHT-2 at that wrap, go to FAIL. Otherwise go to READ.
- WRITE: WrEn=1, WrV/WrH=TryV/TryH, WrData=BLOCK_FOOD, PlaceDone=1. FoodV/FoodH take TryV/TryH and FoodValid goes to 1 on the edge. Go to IDLE.
- FAIL: PlaceFail=1; FoodValid goes to 0 on the edge. Go to IDLE.
- Tries saturates and never wraps. Scan arithmetic is unsigned, and wrap decisions are taken before the increment.
- PlaceReq outside IDLE is ignored. A request held high through the IDLE return starts another placement on the next cycle.
- RdV/RdH are driven to TryV/TryH in all states and are meaningful only in READ.

## Timing

- Reset values: state IDLE, Tries 0, TryV/TryH 0, RdV/RdH 0, WrEn 0, WrV/WrH 0, WrData BLOCK_EMPTY, PlaceBusy 0, PlaceDone 0, PlaceFail 0, FoodV/FoodH 0, FoodValid 0.
- Reset asserted mid-placement: immediate return to IDLE, with no WrEn issued afterwards.
- Best-case latency with PlaceReq sampled high in IDLE at edge 0: SAMPLE in cycle 1, READ in cycle 2, CHECK in cycle 3, WRITE in cycle 4 (WrEn/PlaceDone high during cycle 4). FoodV/FoodH update at edge 5.
- Each occupied random try costs 3 cycles. Each out-of-bounds try costs 1 cycle. Each scanned cell costs 2 cycles.
- Worst case: MAX_TRIES*3 + 2*(GRID_WIDTH-2)*(GRID_HEIGHT-2) + 2 cycles.
- Exactly one WrEn per PlaceDone. PlaceDone and PlaceFail are never high together.

## Test plan

- Empty interior, CandV=5/CandH=7 constant, PlaceReq pulse -> WrEn in cycle 4 at (5,7) with WrData=3. FoodV=5, FoodH=7 and FoodValid=1 from edge 5.
- Candidate (0,7) for 2 cycles, then (5,7) -> 2 rejected tries with no read, then WrEn at (5,7) in cycle 6.
- Cell (5,7) occupied, candidate then changes to (6,8) -> one extra 3-cycle try, then WrEn at (6,8) in cycle 7.
- MAX_TRIES=8, all candidates occupied, only (1,3) empty -> after 8 tries, scan reads (1,1), (1,2), (1,3) and writes (1,3).
- Interior fully occupied -> scan reaches (22,30). Then PlaceFail pulses once, there is no WrEn, FoodValid=0 and the block returns to IDLE.
- ResetN pulled low during CHECK -> all outputs at reset values, no WrEn. A new PlaceReq after release completes normally.

Source files
------------

// File: rtl/food_placer.sv
// rtl/food_placer.sv - validates random food candidates against the grid and commits one food block
module food_placer #(
  parameter int GRID_WIDTH     = 32,
  parameter int GRID_HEIGHT    = 24,
  parameter int BITS_PER_BLOCK = 2,
  parameter int BLOCK_EMPTY    = 0,
  parameter int BLOCK_FOOD     = 3,
  parameter int MAX_TRIES      = 8,
  localparam int VW = $clog2(GRID_HEIGHT),
  localparam int HW = $clog2(GRID_WIDTH)
) (
  input  logic                      MasterClock,
  input  logic                      ResetN,
  input  logic                      PlaceReq,
  input  logic [VW-1:0]             CandV,
  input  logic [HW-1:0]             CandH,
  output logic [VW-1:0]             RdV,
  output logic [HW-1:0]             RdH,
  input  logic [BITS_PER_BLOCK-1:0] RdData,
  output logic                      WrEn,
  output logic [VW-1:0]             WrV,
  output logic [HW-1:0]             WrH,
  output logic [BITS_PER_BLOCK-1:0] WrData,
  output logic                      PlaceBusy,
  output logic                      PlaceDone,
  output logic                      PlaceFail,
  output logic [VW-1:0]             FoodV,
  output logic [HW-1:0]             FoodH,
  output logic                      FoodValid
);

  localparam logic [VW-1:0] V_FIRST = VW'(1);
  localparam logic [VW-1:0] V_LAST  = VW'(GRID_HEIGHT - 2);
  localparam logic [HW-1:0] H_FIRST = HW'(1);
  localparam logic [HW-1:0] H_LAST  = HW'(GRID_WIDTH - 2);
  localparam logic [7:0]    TRIES_LIMIT = 8'(MAX_TRIES);
  localparam logic [BITS_PER_BLOCK-1:0] CODE_EMPTY = BITS_PER_BLOCK'(BLOCK_EMPTY);
  localparam logic [BITS_PER_BLOCK-1:0] CODE_FOOD  = BITS_PER_BLOCK'(BLOCK_FOOD);

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    READ,
    CHECK,
    WRITE,
    FAIL
  } stateT;

  stateT         state;
  logic          modeScan;
  logic [7:0]    tries;
  logic [VW-1:0] tryV;
  logic [HW-1:0] tryH;

  logic          candInterior;
  logic [7:0]    triesInc;
  logic          triesExhausted;

  // Candidate bounds test and the saturating try count shared by SAMPLE and CHECK
  always_comb begin
    candInterior   = (CandV >= V_FIRST) && (CandV <= V_LAST) &&
                     (CandH >= H_FIRST) && (CandH <= H_LAST);
    triesInc       = (tries == 8'hFF) ? tries : tries + 8'd1;
    triesExhausted = (triesInc >= TRIES_LIMIT);
  end

  // The read address always follows the current try; the memory only uses it in READ
  assign RdV = tryV;
  assign RdH = tryH;

  // Placement FSM with registered strobes and food position
  always_ff @(posedge MasterClock or negedge ResetN) begin
    if (!ResetN) begin
      state     <= IDLE;
      modeScan  <= 1'b0;
      tries     <= 8'd0;
      tryV      <= '0;
      tryH      <= '0;
      WrEn      <= 1'b0;
      WrV       <= '0;
      WrH       <= '0;
      WrData    <= CODE_EMPTY;
      PlaceBusy <= 1'b0;
      PlaceDone <= 1'b0;
      PlaceFail <= 1'b0;
      FoodV     <= '0;
      FoodH     <= '0;
      FoodValid <= 1'b0;
    end else begin
      WrEn      <= 1'b0;
      PlaceDone <= 1'b0;
      PlaceFail <= 1'b0;
      WrData    <= CODE_EMPTY;
      case (state)
        IDLE: begin
          if (PlaceReq) begin
            tries     <= 8'd0;
            modeScan  <= 1'b0;
            PlaceBusy <= 1'b1;
            state     <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (candInterior) begin
            tryV  <= CandV;
            tryH  <= CandH;
            state <= READ;
          end else begin
            tries <= triesInc;
            if (triesExhausted) begin
              modeScan <= 1'b1;
              tryV     <= V_FIRST;
              tryH     <= H_FIRST;
              state    <= READ;
            end else begin
              tryV <= CandV;
              tryH <= CandH;
            end
          end
        end
        READ: begin
          state <= CHECK;
        end
        CHECK: begin
          if (RdData == CODE_EMPTY) begin
            WrEn      <= 1'b1;
            PlaceDone <= 1'b1;
            WrV       <= tryV;
            WrH       <= tryH;
            WrData    <= CODE_FOOD;
            state     <= WRITE;
          end else if (!modeScan) begin
            tries <= triesInc;
            if (triesExhausted) begin
              modeScan <= 1'b1;
              tryV     <= V_FIRST;
              tryH     <= H_FIRST;
              state    <= READ;
            end else begin
              state <= SAMPLE;
            end
          end else if (tryH == H_LAST) begin
            // Row wrap; the last interior row wrapping means every cell was occupied
            tryH <= H_FIRST;
            tryV <= tryV + VW'(1);
            if (tryV == V_LAST) begin
              PlaceFail <= 1'b1;
              state     <= FAIL;
            end else begin
              state <= READ;
            end
          end else begin
            tryH  <= tryH + HW'(1);
            state <= READ;
          end
        end
        WRITE: begin
          FoodV     <= tryV;
          FoodH     <= tryH;
          FoodValid <= 1'b1;
          PlaceBusy <= 1'b0;
          state     <= IDLE;
        end
        FAIL: begin
          FoodValid <= 1'b0;
          PlaceBusy <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          PlaceBusy <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_food_placer.sv
// tb/tb_food_placer.sv - randomized self-checking bench for food_placer against a cycle-cost model
module tb_food_placer;

  localparam int GW = 32;
  localparam int GH = 24;
  localparam int MT = 8;
  localparam int NCAND = 64;

  logic       MasterClock = 1'b0;
  logic       ResetN;
  logic       PlaceReq;
  logic [4:0] CandV, CandH;
  logic [4:0] RdV, RdH;
  logic [1:0] RdData;
  logic       WrEn;
  logic [4:0] WrV, WrH;
  logic [1:0] WrData;
  logic       PlaceBusy, PlaceDone, PlaceFail;
  logic [4:0] FoodV, FoodH;
  logic       FoodValid;

  int grid [GH][GW];
  int candV [NCAND];
  int candH [NCAND];
  int nCompared = 0;
  int nMismatched = 0;

  food_placer #(
    .GRID_WIDTH(GW), .GRID_HEIGHT(GH), .BITS_PER_BLOCK(2),
    .BLOCK_EMPTY(0), .BLOCK_FOOD(3), .MAX_TRIES(MT)
  ) dut (
    .MasterClock(MasterClock), .ResetN(ResetN), .PlaceReq(PlaceReq),
    .CandV(CandV), .CandH(CandH), .RdV(RdV), .RdH(RdH), .RdData(RdData),
    .WrEn(WrEn), .WrV(WrV), .WrH(WrH), .WrData(WrData),
    .PlaceBusy(PlaceBusy), .PlaceDone(PlaceDone), .PlaceFail(PlaceFail),
    .FoodV(FoodV), .FoodH(FoodH), .FoodValid(FoodValid)
  );

  always #5 MasterClock = ~MasterClock;

  // Grid memory with one cycle of read latency
  always @(posedge MasterClock)
    RdData <= (RdV < GH && RdH < GW) ? 2'(grid[RdV][RdH]) : 2'd0;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit isInterior(input int v, input int h);
    return (v >= 1) && (v <= GH - 2) && (h >= 1) && (h <= GW - 2);
  endfunction

  // Cost model: out-of-bounds try 1 cycle, occupied random try 3, scanned cell 2
  function automatic void predict(output int evCycle, output bit evFail,
                                  output int evV, output int evH);
    int t;
    int tries;
    t = 1;
    tries = 0;
    evFail = 1'b0;
    evV = 0;
    evH = 0;
    while (tries < MT) begin
      if (isInterior(candV[t], candH[t])) begin
        if (grid[candV[t]][candH[t]] == 0) begin
          evCycle = t + 3;
          evV = candV[t];
          evH = candH[t];
          return;
        end
        tries++;
        t += 3;
      end else begin
        tries++;
        t += 1;
      end
    end
    for (int v = 1; v <= GH - 2; v++)
      for (int h = 1; h <= GW - 2; h++) begin
        if (grid[v][h] == 0) begin
          evCycle = t + 2;
          evV = v;
          evH = h;
          return;
        end
        t += 2;
      end
    evFail = 1'b1;
    evCycle = t;
  endfunction

  task automatic setGrid(input int pct);
    for (int v = 0; v < GH; v++)
      for (int h = 0; h < GW; h++)
        if (!isInterior(v, h)) grid[v][h] = 1;
        else grid[v][h] = ($urandom_range(99) < pct) ? int'($urandom_range(2, 1)) : 0;
  endtask

  task automatic fillCands(input int v, input int h);
    for (int i = 0; i < NCAND; i++) begin
      candV[i] = v;
      candH[i] = h;
    end
  endtask

  task automatic driveCand(input int k);
    CandV = 5'(candV[k < NCAND ? k : 0]);
    CandH = 5'(candH[k < NCAND ? k : 0]);
  endtask

  // Called just after a rising edge with the DUT idle
  task automatic runPlacement(input string tag);
    int  expCycle, expV, expH, k;
    bit  expFail, seen, busyBad, pulseBad;
    predict(expCycle, expFail, expV, expH);
    PlaceReq = 1'b1;
    driveCand(0);
    @(posedge MasterClock); #1;
    PlaceReq = 1'b0;
    k = 1;
    driveCand(k);
    seen = 0;
    busyBad = 0;
    pulseBad = 0;
    while (!seen && k < 3000) begin
      @(negedge MasterClock);
      if (!PlaceBusy) busyBad = 1;
      if ((PlaceDone !== WrEn) || (PlaceDone && PlaceFail)) pulseBad = 1;
      if (WrEn || PlaceFail) begin
        seen = 1;
        checkEq({tag, " event cycle"}, k, expCycle);
        checkEq({tag, " fail flag"}, PlaceFail, expFail);
        if (WrEn) begin
          checkEq({tag, " WrV"}, WrV, expV);
          checkEq({tag, " WrH"}, WrH, expH);
          checkEq({tag, " WrData"}, WrData, 3);
          grid[WrV][WrH] = WrData;
        end
      end
      @(posedge MasterClock); #1;
      k++;
      driveCand(k);
    end
    checkEq({tag, " event seen"}, seen, 1);
    checkEq({tag, " busy held"}, busyBad, 0);
    checkEq({tag, " pulse pairing"}, pulseBad, 0);
    @(negedge MasterClock);
    checkEq({tag, " idle after"}, PlaceBusy, 0);
    checkEq({tag, " no extra strobe"}, {WrEn, PlaceDone, PlaceFail}, 0);
    checkEq({tag, " FoodValid"}, FoodValid, !expFail);
    if (!expFail) begin
      checkEq({tag, " FoodV"}, FoodV, expV);
      checkEq({tag, " FoodH"}, FoodH, expH);
    end
    @(posedge MasterClock); #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkEq({tag, " RdV/RdH"}, {RdV, RdH}, 0);
    checkEq({tag, " WrEn"}, WrEn, 0);
    checkEq({tag, " WrV/WrH"}, {WrV, WrH}, 0);
    checkEq({tag, " WrData"}, WrData, 0);
    checkEq({tag, " strobes"}, {PlaceBusy, PlaceDone, PlaceFail}, 0);
    checkEq({tag, " FoodV/FoodH"}, {FoodV, FoodH}, 0);
    checkEq({tag, " FoodValid"}, FoodValid, 0);
  endtask

  initial begin
    int pctTable [5];
    bit wrSeen;
    pctTable = '{0, 30, 70, 95, 100};
    ResetN = 1'b0;
    PlaceReq = 1'b0;
    CandV = '0;
    CandH = '0;
    setGrid(0);
    #2;
    checkResetOutputs("reset");
    repeat (3) @(posedge MasterClock);
    #1;
    ResetN = 1'b1;
    @(posedge MasterClock); #1;

    setGrid(0);
    fillCands(5, 7);
    runPlacement("direct best case");

    setGrid(0);
    fillCands(5, 7);
    candV[1] = 0; candV[2] = 0;
    runPlacement("direct out of bounds");

    setGrid(0);
    grid[5][7] = 1;
    fillCands(6, 8);
    for (int i = 0; i < 4; i++) begin
      candV[i] = 5;
      candH[i] = 7;
    end
    runPlacement("direct occupied retry");

    setGrid(100);
    grid[1][3] = 0;
    fillCands(2, 2);
    runPlacement("direct scan");

    setGrid(100);
    for (int i = 0; i < NCAND; i++) begin
      candV[i] = int'($urandom_range(31));
      candH[i] = int'($urandom_range(31));
    end
    runPlacement("direct full");

    for (int r = 0; r < 12; r++) begin
      setGrid(pctTable[r % 5]);
      for (int i = 0; i < NCAND; i++) begin
        candV[i] = int'($urandom_range(31));
        candH[i] = int'($urandom_range(31));
      end
      runPlacement($sformatf("random round %0d", r));
    end

    // Reset pulled low while the first read is being checked
    setGrid(0);
    fillCands(5, 7);
    PlaceReq = 1'b1;
    driveCand(0);
    @(posedge MasterClock); #1;
    PlaceReq = 1'b0;
    repeat (2) @(posedge MasterClock);
    @(negedge MasterClock);
    ResetN = 1'b0;
    #1;
    checkResetOutputs("mid reset");
    wrSeen = 0;
    repeat (6) begin
      @(negedge MasterClock);
      if (WrEn || PlaceDone) wrSeen = 1;
    end
    checkEq("mid reset no write", wrSeen, 0);
    @(posedge MasterClock); #1;
    ResetN = 1'b1;
    @(posedge MasterClock); #1;
    runPlacement("after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
